// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// The state enum, op encodings and iteration count live here so the FSM and datapath agree.
package muldiv_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDiv,
    StFix,
    StDone
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct when read unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 Booth multiply and restoring divide on shared shift registers.
// The FSM in muldiv_ctrl drives init (load operands) and step (one iteration).
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        step,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  // acc is 33 bits so Booth can subtract -2^31 without losing the sign.
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [32:0] m_q;
  logic        op_q;
  logic        qneg_q;
  logic        rneg_q;

  logic [32:0] booth_sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    booth_sum = acc_q;
    shifted   = {acc_q[31:0], q_q[31]};
    diff      = shifted - m_q;
    if (op_q == OP_MULT) begin
      case ({q_q[0], qm1_q})
        2'b10:   booth_sum = acc_q - m_q;
        2'b01:   booth_sum = acc_q + m_q;
        default: booth_sum = acc_q;
      endcase
      acc_d = {booth_sum[32], booth_sum[32:1]};
      q_d   = {booth_sum[0], q_q[31:1]};
      qm1_d = q_q[0];
    end else begin
      if (shifted >= m_q) begin
        acc_d = diff;
        q_d   = {q_q[30:0], 1'b1};
      end else begin
        acc_d = shifted;
        q_d   = {q_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      m_q    <= '0;
      op_q   <= OP_MULT;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (init) begin
      op_q  <= op;
      acc_q <= '0;
      qm1_q <= 1'b0;
      if (op == OP_MULT) begin
        q_q    <= a;
        m_q    <= {b[31], b};
        qneg_q <= 1'b0;
        rneg_q <= 1'b0;
      end else begin
        q_q    <= mag32(a);
        m_q    <= {1'b0, mag32(b)};
        qneg_q <= a[31] ^ b[31];
        rneg_q <= a[31];
      end
    end else if (step) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
    end
  end

  // Sign correction for divide; sampled by the FSM during FIX.
  always_comb begin
    res_hi = acc_q[31:0];
    res_lo = q_q;
    if (op_q == OP_DIV) begin
      if (rneg_q) res_hi = ~acc_q[31:0] + 32'd1;
      if (qneg_q) res_lo = ~q_q + 32'd1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Control FSM for the iterative signed multiply/divide unit.
// Sequences IDLE -> MULT/DIV (32 steps) -> FIX -> DONE and holds hi/lo between results.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, lo_q;
  logic             core_init;
  logic             core_step;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  muldiv_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (core_init),
    .step   (core_step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    core_init = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          core_init = 1'b1;
          cnt_d     = '0;
          if (op == OP_DIV) begin
            // Divide by zero skips the datapath entirely.
            if (b == 32'd0) begin
              state_d = StDone;
              dz_d    = 1'b1;
            end else begin
              state_d = StDiv;
              dz_d    = 1'b0;
            end
          end else begin
            state_d = StMult;
            dz_d    = 1'b0;
          end
        end
      end
      StMult, StDiv: begin
        core_step = 1'b1;
        if (cnt_q == LastIter) begin
          cnt_d   = '0;
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFix: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        dz_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      if (state_q == StFix) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign div_zero = (state_q == StDone) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: expected results are queued at issue and
// popped when done is seen, including latency from the accepting edge.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] model(input logic o, input logic [31:0] av, input logic [31:0] bv);
    longint      pa;
    longint      pb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] qv;
    logic [31:0] rv;
    if (!o) begin
      pa = longint'($signed(av));
      pb = longint'($signed(bv));
      return 64'(pa * pb);
    end
    ma = av[31] ? -av : av;
    mb = bv[31] ? -bv : bv;
    qv = ma / mb;
    rv = ma % mb;
    if (av[31] ^ bv[31]) qv = -qv;
    if (av[31]) rv = -rv;
    return {rv, qv};
  endfunction

  // Start is sampled at the next rising edge; operands are scrambled right after acceptance.
  task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 1'($urandom);
  endtask

  // Latency is counted in rising edges after the accepting edge.
  task automatic wait_done(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", div_zero); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] av, bv;
    logic [63:0] m;
    exp_t        e;
    int          lat;
    bit          ok;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin av = 32'd7; bv = 32'hFFFF_FFFD; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB; end
        1: begin av = 32'h8000_0000; bv = 32'h8000_0000; e.hi = 32'h4000_0000; e.lo = 32'h0; end
        default: begin
          av = $urandom; bv = $urandom;
          m = model(1'b0, av, bv); e.hi = m[63:32]; e.lo = m[31:0];
        end
      endcase
      e.dz = 1'b0; e.lat = 33;
      sb.push_back(e);
      issue(1'b0, av, bv);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult%0d_busy got=%b want=1", i, busy); end
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL mult%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL mult%0d_hi got=%h want=%h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL mult%0d_lo got=%h want=%h", i, lo, e.lo); end
      checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL mult%0d_dz got=%b want=%b", i, div_zero, e.dz); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult%0d_after done=%b busy=%b want 0/0", i, done, busy); end
    end
  endtask

  task automatic test_div();
    logic [31:0] av, bv;
    logic [63:0] m;
    exp_t        e;
    int          lat;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin av = 32'hFFFF_FFF9; bv = 32'd2; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFD; end
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; e.hi = 32'h0; e.lo = 32'h8000_0000; end
        default: begin
          av = $urandom; bv = (i == 5) ? 32'($urandom_range(1, 300)) : $urandom;
          if (bv == 0) bv = 32'd1;
          m = model(1'b1, av, bv); e.hi = m[63:32]; e.lo = m[31:0];
        end
      endcase
      e.dz = 1'b0; e.lat = 33;
      sb.push_back(e);
      issue(1'b1, av, bv);
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL div%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL div%0d_hi got=%h want=%h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL div%0d_lo got=%h want=%h", i, lo, e.lo); end
      checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL div%0d_dz got=%b want=%b", i, div_zero, e.dz); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   lat;
    bit   ok;
    sb.push_back('{hi: 32'd1, lo: 32'd2, dz: 1'b0, lat: 33});
    sb.push_back('{hi: 32'd1, lo: 32'd2, dz: 1'b1, lat: 0});
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 32'd5, (i == 0) ? 32'd2 : 32'd0);
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL dz%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL dz%0d_hi got=%h want=%h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL dz%0d_lo got=%h want=%h", i, lo, e.lo); end
      checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL dz%0d_flag got=%b want=%b", i, div_zero, e.dz); end
      @(posedge clk); #1;
      checks++; if (div_zero !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dz%0d_pulse dz=%b done=%b want 0/0", i, div_zero, done); end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    bit   ok;
    // A divide-by-zero start mid-multiply would finish at once if it were wrongly accepted.
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0, lat: 28});
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_state busy=%b done=%b want 1/0", busy, done); end
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL ign_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL ign_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL ign_dz got=%b want=%b", div_zero, e.dz); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   ok;
    sb.push_back('{hi: 32'd0, lo: 32'd30, dz: 1'b0, lat: 33});
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0, lat: 33});
    issue(1'b0, 32'd5, 32'd6);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL b2b0_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b0_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    // Start raised during DONE must be ignored there and only accepted once back in IDLE.
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start busy=%b want=0", busy); end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want=1", busy); end
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL b2b1_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b1_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    bit   ok;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL rmid_ctrl busy=%b done=%b dz=%b want 0/0/0", busy, done, div_zero); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rmid_data got=%h_%h want=0_0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{hi: 32'd0, lo: 32'd12, dz: 1'b0, lat: 33});
    issue(1'b0, 32'd3, 32'd4);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL rmid_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL rmid_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
